ide_sector_xfer: RTL

- Sector-level ATA PIO controller that sits directly upstream of the IDE bus-cycle engine and drives its ata_rd/ata_wr/ata_addr/ata_in/ata_done handshake.
- Takes a single-sector read or write request with a 28-bit LBA and programs the task file.
- Polls status, then moves 256 16-bit words between the drive and a synchronous sector buffer.
- Serves the disk-emulation front end, which only sees start/busy/done/error.

---
 rtl/ide_sector_xfer.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ide_sector_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ide_sector_xfer : single-sector ATA PIO read/write sequencer driving  |
// | the IDE bus-cycle engine. Optional macro: IDE_SECTOR_XFER_TIMEOUT_EN  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ide_sector_xfer #(
  parameter logic [23:0] POLL_LIMIT = 24'd5000000,
  parameter logic [8:0]  WORDS      = 9'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [27:0] lba,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_status,
  output logic        ata_rd,
  output logic        ata_wr,
  output logic [4:0]  ata_addr,
  output logic [15:0] ata_out,
  input  logic [15:0] ata_in,
  input  logic        ata_done,
  output logic [7:0]  buf_addr,
  output logic        buf_wr,
  output logic [15:0] buf_wdata,
  input  logic [15:0] buf_rdata
);

  localparam logic [4:0] c_reg_data   = 5'h10;
  localparam logic [4:0] c_reg_seccnt = 5'h12;
  localparam logic [4:0] c_reg_lba0   = 5'h13;
  localparam logic [4:0] c_reg_lba1   = 5'h14;
  localparam logic [4:0] c_reg_lba2   = 5'h15;
  localparam logic [4:0] c_reg_dev    = 5'h16;
  localparam logic [4:0] c_reg_status = 5'h17;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_SET_CNT, S_SET_LBA0, S_SET_LBA1, S_SET_LBA2,
    S_SET_DEV, S_SET_CMD, S_WAIT_DRQ, S_XFER, S_WAIT_END, S_DONE, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [27:0] lba_q, lba_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [7:0]  err_status_q, err_status_d;
  logic        ata_rd_q, ata_rd_d, ata_wr_q, ata_wr_d;
  logic [4:0]  ata_addr_q, ata_addr_d;
  logic [15:0] ata_out_q, ata_out_d;
  logic [7:0]  buf_addr_q, buf_addr_d;
  logic        buf_wr_q, buf_wr_d;
  logic [15:0] buf_wdata_q, buf_wdata_d;
  logic [8:0]  count_q, count_d;
  logic [1:0]  gap_q, gap_d, fetch_q, fetch_d;

  logic        issue_rd, issue_wr, finish_ok, finish_err;
  logic [4:0]  issue_addr;
  logic [15:0] issue_data;
  logic [7:0]  fail_status, status;
  logic        op_q, op_done, can_issue, in_poll;

  assign status    = ata_in[7:0];
  assign op_q      = ata_rd_q | ata_wr_q;
  assign op_done   = op_q & ata_done;
  // gap_q==1 means the second idle cycle is in progress: the next op may go out on this edge
  assign can_issue = !op_q && (gap_q <= 2'd1);
  assign in_poll   = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_DRQ) || (state_q == S_WAIT_END);

`ifdef IDE_SECTOR_XFER_TIMEOUT_EN
  logic [23:0] poll_q, poll_d;
  always_comb poll_d = (state_d != state_q || !in_poll) ? 24'd0 : poll_q + 24'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_q <= 24'd0;
    else       poll_q <= poll_d;
  end
`else
  logic unused_poll;
  assign unused_poll = ^POLL_LIMIT ^ in_poll;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    lba_d        = lba_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_status_d = err_status_q;
    ata_rd_d     = ata_rd_q;
    ata_wr_d     = ata_wr_q;
    ata_addr_d   = ata_addr_q;
    ata_out_d    = ata_out_q;
    buf_addr_d   = buf_addr_q;
    buf_wr_d     = 1'b0;
    buf_wdata_d  = buf_wdata_q;
    count_d      = count_q;
    fetch_d      = fetch_q;
    gap_d        = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
    issue_rd     = 1'b0;
    issue_wr     = 1'b0;
    issue_addr   = c_reg_status;
    issue_data   = 16'h0000;
    finish_ok    = 1'b0;
    finish_err   = 1'b0;
    fail_status  = status;

    if (op_done) begin
      ata_rd_d = 1'b0;
      ata_wr_d = 1'b0;
      gap_d    = 2'd2;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_write_d = cmd_write;
          lba_d       = lba;
          busy_d      = 1'b1;
          state_d     = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        issue_rd = can_issue;
        if (op_done && !status[7] && status[6]) state_d = S_SET_CNT;
      end
      S_SET_CNT: begin
        issue_wr = can_issue; issue_addr = c_reg_seccnt; issue_data = 16'h0001;
        if (op_done) state_d = S_SET_LBA0;
      end
      S_SET_LBA0: begin
        issue_wr = can_issue; issue_addr = c_reg_lba0; issue_data = {8'h00, lba_q[7:0]};
        if (op_done) state_d = S_SET_LBA1;
      end
      S_SET_LBA1: begin
        issue_wr = can_issue; issue_addr = c_reg_lba1; issue_data = {8'h00, lba_q[15:8]};
        if (op_done) state_d = S_SET_LBA2;
      end
      S_SET_LBA2: begin
        issue_wr = can_issue; issue_addr = c_reg_lba2; issue_data = {8'h00, lba_q[23:16]};
        if (op_done) state_d = S_SET_DEV;
      end
      S_SET_DEV: begin
        issue_wr = can_issue; issue_addr = c_reg_dev; issue_data = {8'h00, 4'hE, lba_q[27:24]};
        if (op_done) state_d = S_SET_CMD;
      end
      S_SET_CMD: begin
        issue_wr = can_issue; issue_addr = c_reg_status;
        issue_data = cmd_write_q ? 16'h0030 : 16'h0020;
        if (op_done) state_d = S_WAIT_DRQ;
      end
      S_WAIT_DRQ: begin
        issue_rd = can_issue;
        if (op_done && !status[7]) begin
          if (status[0]) begin
            finish_err = 1'b1;
          end else if (status[3]) begin
            state_d = S_XFER;
            count_d = 9'd0;
            fetch_d = 2'd0;
          end
        end
      end
      S_XFER: begin
        issue_addr = c_reg_data;
        if (cmd_write_q) begin
          // buffer word is addressed, waited on for its read latency, then sent
          if (can_issue) begin
            case (fetch_q)
              2'd0:    begin buf_addr_d = count_q[7:0]; fetch_d = 2'd1; end
              2'd1:    fetch_d = 2'd2;
              default: begin issue_wr = 1'b1; issue_data = buf_rdata; fetch_d = 2'd0; end
            endcase
          end
        end else begin
          issue_rd = can_issue;
          if (op_done) begin
            buf_wr_d    = 1'b1;
            buf_addr_d  = count_q[7:0];
            buf_wdata_d = ata_in;
          end
        end
        if (op_done) begin
          if (count_q == WORDS - 9'd1) state_d = S_WAIT_END;
          else                         count_d = count_q + 9'd1;
        end
      end
      S_WAIT_END: begin
        issue_rd = can_issue;
        if (op_done && !status[7]) begin
          if (status[0]) finish_err = 1'b1;
          else           finish_ok  = 1'b1;
        end
      end
      S_DONE, S_FAIL: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase

    if (issue_rd || issue_wr) begin
      ata_rd_d   = issue_rd;
      ata_wr_d   = issue_wr;
      ata_addr_d = issue_addr;
      if (issue_wr) ata_out_d = issue_data;
    end

`ifdef IDE_SECTOR_XFER_TIMEOUT_EN
    if (in_poll && poll_q == POLL_LIMIT - 24'd1) begin
      finish_err  = 1'b1;
      fail_status = 8'hFF;
      ata_rd_d    = 1'b0;
      ata_wr_d    = 1'b0;
      gap_d       = 2'd2;
    end
`endif

    if (finish_err) begin
      state_d      = S_FAIL;
      error_d      = 1'b1;
      busy_d       = 1'b0;
      err_status_d = fail_status;
    end else if (finish_ok) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_write_q  <= 1'b0;
      lba_q        <= 28'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_status_q <= 8'h00;
      ata_rd_q     <= 1'b0;
      ata_wr_q     <= 1'b0;
      ata_addr_q   <= 5'd0;
      ata_out_q    <= 16'h0000;
      buf_addr_q   <= 8'h00;
      buf_wr_q     <= 1'b0;
      buf_wdata_q  <= 16'h0000;
      count_q      <= 9'd0;
      gap_q        <= 2'd0;
      fetch_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      lba_q        <= lba_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_status_q <= err_status_d;
      ata_rd_q     <= ata_rd_d;
      ata_wr_q     <= ata_wr_d;
      ata_addr_q   <= ata_addr_d;
      ata_out_q    <= ata_out_d;
      buf_addr_q   <= buf_addr_d;
      buf_wr_q     <= buf_wr_d;
      buf_wdata_q  <= buf_wdata_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      fetch_q      <= fetch_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_status = err_status_q;
  assign ata_rd     = ata_rd_q;
  assign ata_wr     = ata_wr_q;
  assign ata_addr   = ata_addr_q;
  assign ata_out    = ata_out_q;
  assign buf_addr   = buf_addr_q;
  assign buf_wr     = buf_wr_q;
  assign buf_wdata  = buf_wdata_q;

endmodule
`default_nettype wire
